// File: rtl/mealy_seq_pkg.sv
// Shared types and width helpers for the
// parametrised Mealy pattern detector.
package mealy_seq_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int len_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Longest pattern prefix that ends on the
// incoming bit, limited by valid history.
module seq_prefix_match #(
  parameter int N  = 2,
  parameter int LW = 2
) (
  input  logic [N-2:0]  hist,
  input  logic          din,
  input  logic [N-1:0]  pat,
  input  logic [LW-1:0] fill,
  output logic [LW-1:0] k
);

  logic [N-1:0] cand;

  assign cand = {hist, din};

  // ascending scan: the last hit is the longest
  always_comb begin
    k = '0;
    for (int j = 1; j <= N; j++) begin
      if ((int'(fill) + 1 >= j) &&
          (((cand ^ (pat >> (N - j))) &
            ({N{1'b1}} >> (N - j))) == '0))
        k = LW'(j);
    end
  end

endmodule

// File: rtl/mealy_seq_detector_param.sv
// Programmable N-bit Mealy serial detector
// with overlap select and saturating count.
module mealy_seq_detector_param
  import mealy_seq_pkg::*;
#(
  parameter int           N       = 2,
  parameter logic [N-1:0] RST_PAT = 2'b11,
  parameter int           CW      = 8,
  localparam int          LW      = len_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          din_valid,
  input  logic          din,
  input  logic          overlap,
  input  logic          pat_load,
  input  logic [N-1:0]  pat_in,
  input  logic          cnt_clr,
  output logic          match,
  output logic [CW-1:0] match_cnt,
  output logic [LW-1:0] match_len
);

  state_t state_q, state_d;

  logic [N-1:0]  pat_q;
  logic [N-2:0]  hist_q;
  logic [LW-1:0] fill_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] k;
  logic [CW-1:0] cnt_q;
  logic          acc;
  logic          hit;

  seq_prefix_match #(
    .N  (N),
    .LW (LW)
  ) u_pm (
    .hist (hist_q),
    .din  (din),
    .pat  (pat_q),
    .fill (fill_q),
    .k    (k)
  );

  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    hit     = 1'b0;
    unique case (state_q)
      IDLE: state_d = RUN;
      RUN:  acc = en & din_valid
                & ~pat_load & ~rst;
    endcase
    if (pat_load)
      state_d = IDLE;
    hit = acc & (k == LW'(N));
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // only N-1 history bits can feed a match
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= RST_PAT;
      hist_q <= '0;
      fill_q <= '0;
      len_q  <= '0;
    end else if (pat_load) begin
      pat_q  <= pat_in;
      fill_q <= '0;
      len_q  <= '0;
    end else if (acc) begin
      hist_q <= (hist_q << 1)
              | (N-1)'(din);
      if (hit & ~overlap) begin
        fill_q <= '0;
        len_q  <= '0;
      end else begin
        if (fill_q != LW'(N))
          fill_q <= fill_q + 1'b1;
        len_q <= k;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst | cnt_clr)
      cnt_q <= '0;
    else if (hit && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign match     = hit;
  assign match_cnt = cnt_q;
  assign match_len = len_q;

endmodule
